// File: rtl/baud_tick_nco.sv
// Phase-accumulator baud generator: emits oversample ticks and bit ticks at
// CLK_FREQ*inc/2^ACC_WIDTH, with runtime increment load and RX phase resync.
module baud_tick_nco #(
    parameter int unsigned     CLK_FREQ     = 100000000,
    parameter int unsigned     BAUD_RATE    = 115200,
    parameter int unsigned     OVERSAMPLING = 16,
    parameter int unsigned     ACC_WIDTH    = 24,
    parameter longint unsigned INC_RESET    =
        (((64'(BAUD_RATE) * 64'(OVERSAMPLING)) << ACC_WIDTH) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ),
    parameter int unsigned     OS_WIDTH     = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [ACC_WIDTH-1:0] i_inc,
    input  logic                 i_inc_load,
    input  logic                 i_resync,
    output logic                 o_os_tick,
    output logic                 o_bit_tick,
    output logic [OS_WIDTH-1:0]  o_os_index,
    output logic [ACC_WIDTH-1:0] o_inc
);

    localparam int unsigned          SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic [OS_WIDTH-1:0]  OS_LAST   = OS_WIDTH'(OVERSAMPLING - 1);
    localparam logic [ACC_WIDTH-1:0] INC_INIT  = ACC_WIDTH'(INC_RESET);

    // Parameter legality is enforced at elaboration.
    if (OVERSAMPLING < 1 || OVERSAMPLING > 256) begin : g_bad_os
        $error("baud_tick_nco: OVERSAMPLING must be in 1..256");
    end
    if (ACC_WIDTH < 4 || ACC_WIDTH > 32) begin : g_bad_acc
        $error("baud_tick_nco: ACC_WIDTH must be in 4..32");
    end
    if (INC_RESET >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
        $error("baud_tick_nco: INC_RESET must be below 2^ACC_WIDTH");
    end

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] inc_q, inc_d;
    logic [OS_WIDTH-1:0]  os_idx_q, os_idx_d;
    logic                 os_tick_q, os_tick_d;
    logic                 bit_tick_q, bit_tick_d;
    logic [SUM_WIDTH-1:0] sum;
    logic                 carry;

    // One extra bit captures the overflow that defines an oversample tick.
    assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry = sum[ACC_WIDTH];

    always_comb begin
        acc_d      = acc_q;
        inc_d      = inc_q;
        os_idx_d   = os_idx_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;

        // The add below still uses inc_q, so a load only affects later cycles.
        if (i_inc_load) begin
            inc_d = i_inc;
        end

        if (i_resync) begin
            acc_d    = '0;
            os_idx_d = '0;
        end else if (i_enable) begin
            acc_d = sum[ACC_WIDTH-1:0];
            if (carry) begin
                os_tick_d = 1'b1;
                if (os_idx_q == OS_LAST) begin
                    os_idx_d   = '0;
                    bit_tick_d = 1'b1;
                end else begin
                    os_idx_d = os_idx_q + OS_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q      <= '0;
            inc_q      <= INC_INIT;
            os_idx_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            os_idx_q   <= os_idx_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign o_os_tick  = os_tick_q;
    assign o_bit_tick = bit_tick_q;
    assign o_os_index = os_idx_q;
    assign o_inc      = inc_q;

endmodule

// File: doc/baud_tick_nco.md
BAUD_TICK_NCO -- requirements
Module: baud_tick_nco

Interface
REQ-001 Parameter CLK_FREQ, default 100000000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200: baud rate loaded into the increment register at reset.
REQ-003 Parameter OVERSAMPLING, default 16: oversample ticks per bit; legal range 1 to 256.
REQ-004 Parameter ACC_WIDTH, default 24: phase accumulator width; legal range 4 to 32.
REQ-005 Parameter INC_RESET, default round(BAUD_RATE*OVERSAMPLING*2^ACC_WIDTH/CLK_FREQ): reset increment; elaboration SHALL fail if it is not below 2^ACC_WIDTH.
REQ-006 Parameter OS_WIDTH, default max(1,$clog2(OVERSAMPLING)): oversample index width.
REQ-007 i_clk  input  1  single clock; all logic on its rising edge.
REQ-008 i_reset  input  1  synchronous, active-high reset.
REQ-009 i_enable  input  1  when high, the accumulator advances.
REQ-010 i_inc  input  ACC_WIDTH  new phase increment.
REQ-011 i_inc_load  input  1  single-cycle strobe that captures i_inc.
REQ-012 i_resync  input  1  single-cycle strobe that restarts the phase and the oversample index (RX start-edge alignment).
REQ-013 o_os_tick  output  1  one-cycle oversample tick.
REQ-014 o_bit_tick  output  1  one-cycle bit tick.
REQ-015 o_os_index  output  OS_WIDTH  current oversample index within the bit.
REQ-016 o_inc  output  ACC_WIDTH  active increment register (readback).

Function
REQ-017 Each enabled cycle, {carry, acc} SHALL equal acc + inc_reg, computed ACC_WIDTH+1 bits wide; the sum wraps modulo 2^ACC_WIDTH.
REQ-018 o_os_tick SHALL be registered and SHALL equal the carry of that add, so it goes high the cycle after the overflowing add (latency 1).
REQ-019 On each carry, os_index SHALL increment; when it equals OVERSAMPLING-1 it SHALL wrap to 0.
REQ-020 o_bit_tick SHALL be registered and SHALL go high in the same cycle as o_os_tick only when that tick wrapped os_index from OVERSAMPLING-1 to 0.
REQ-021 o_os_index SHALL show the index after the update; the value is 0 during the bit_tick cycle.
REQ-022 When i_enable is low, acc and os_index SHALL hold, and o_os_tick and o_bit_tick SHALL be 0 the following cycle.
REQ-023 When i_inc_load is high, inc_reg SHALL take i_inc at the clock edge; the add in that same cycle SHALL use the old value; acc SHALL not be cleared.
REQ-024 inc_reg of 0 SHALL produce no ticks; acc holds.
REQ-025 Because inc_reg is below 2^ACC_WIDTH, at most one carry occurs per cycle; no tick is dropped or merged.
REQ-026 When i_resync is high, acc and os_index SHALL clear to 0, and the next-cycle o_os_tick and o_bit_tick SHALL be 0; the resync overrides the add for that cycle, whether or not i_enable is high.
REQ-027 When i_resync and i_inc_load are high together, both SHALL take effect; the first add after the resync uses the new increment.
REQ-028 Priority: i_reset > i_resync > normal advance; i_inc_load is independent of i_resync and subordinate only to i_reset.
REQ-029 OVERSAMPLING of 1: every o_os_tick SHALL also be an o_bit_tick, and o_os_index SHALL stay 0.
REQ-030 Long-run o_os_tick rate SHALL be CLK_FREQ*inc_reg/2^ACC_WIDTH, with phase error bounded to under one clock period; there is no cumulative drift.

Reset
REQ-031 While i_reset is high at a clock edge: acc=0, os_index=0, inc_reg=INC_RESET, o_os_tick=0, o_bit_tick=0, o_os_index=0, o_inc=INC_RESET.
REQ-032 Reset asserted mid-operation SHALL discard the phase and any pending loaded increment; the first add SHALL occur in the first cycle after i_reset is sampled low.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- ACC_WIDTH=8, OVERSAMPLING=4, INC_RESET=64, i_enable=1 -> o_os_tick every 4th cycle; o_bit_tick every 16th cycle; o_os_index sequence 1,2,3,0.
- ACC_WIDTH=8, load i_inc=96 -> exactly 3 o_os_tick per 8 cycles, repeating pattern, no drift over 800 cycles (300 ticks).
- Defaults (100 MHz, 115200, 16, ACC 24): o_inc=309238; 1,000,000 enabled cycles -> 18432 o_os_tick, 1152 o_bit_tick.
- i_resync pulse with acc=200, os_index=2 (ACC 8, inc 64) -> next cycle no tick, os_index 0; first o_os_tick 4 cycles after the pulse; simultaneous i_inc_load=128 -> ticks every 2 cycles from then on.
- i_enable low for 10 cycles mid-bit -> no ticks, index frozen; on re-enable, ticks resume at the retained phase; i_inc=0 -> no ticks for 1000 cycles.
- i_reset asserted during a bit_tick cycle with inc_reg=128 -> all outputs 0, o_inc back to INC_RESET on the next cycle; normal ticking restarts after release.
